// File: rtl/ttt_move_arbiter.sv
// ttt_move_arbiter: front-end move controller for the tic-tac-toe core.
// Synchronises and debounces the nine cell buttons, turns press edges into
// one legal move, offers it over valid/ready and tracks whose turn it is,
// including a forfeit-on-timeout turn timer.
module ttt_move_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] buttons,
    input  logic [8:0] occupied,
    input  logic       enable,
    input  logic       new_game,
    output logic       move_valid,
    output logic [3:0] move_cell,
    output logic [8:0] move_onehot,
    output logic       move_player,
    input  logic       move_ready,
    output logic       rejected,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam logic [7:0]  DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
    // Only meaningful when the timer is on; a zero timeout wraps here harmlessly.
    localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT_CYCLES - 1);
    localparam bit          TIMER_ON   = (TIMEOUT_CYCLES != 0);

    logic [8:0]  sync1_q, sync2_q;
    logic [8:0]  db_q, db_d, db_prev_q;
    logic [8:0]  press_evt_q;
    logic [7:0]  cnt_q [9];
    logic [7:0]  cnt_d [9];

    state_t      state_q, state_d;
    logic [3:0]  cell_q, cell_d;
    logic        player_q, player_d;
    logic [19:0] timer_q, timer_d;

    logic [8:0]  legal;
    logic [3:0]  pick;

    assign legal = press_evt_q & ~occupied;

    // Per-button stability counters: db follows sync once it has differed long enough.
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 9; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LIMIT) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Synchroniser, debounce state and one-cycle press-edge register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            press_evt_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset with everything else.
            for (int i = 0; i < 9; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= buttons;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            press_evt_q <= db_q & ~db_prev_q;
            cnt_q       <= cnt_d;
        end
    end

    // Lowest-index legal cell wins when several presses arrive together.
    always_comb begin
        pick = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (legal[i]) begin
                pick = 4'(i);
            end
        end
    end

    // Move FSM next state, player/timer updates and the rejected/timeout pulses.
    always_comb begin
        state_d  = state_q;
        cell_d   = cell_q;
        player_d = player_q;
        timer_d  = timer_q;
        rejected = 1'b0;
        timeout  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    rejected = |(press_evt_q & occupied);
                    if (|legal) begin
                        // A legal press beats a timeout landing in the same cycle.
                        cell_d  = pick;
                        state_d = OFFER;
                    end else if (TIMER_ON) begin
                        if (timer_q == TIMER_LAST) begin
                            timeout  = 1'b1;
                            player_d = ~player_q;
                            timer_d  = '0;
                        end else begin
                            timer_d = timer_q + 20'd1;
                        end
                    end
                end
            end
            OFFER: begin
                if (!enable) begin
                    // Offer withdrawn; the turn stays with the same player.
                    state_d = IDLE;
                end else if (move_ready) begin
                    player_d = ~player_q;
                    timer_d  = '0;
                    state_d  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (db_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            timer_d = '0;
        end

        // A fresh game overrides any handshake or timeout in the same cycle.
        if (new_game) begin
            state_d  = WAIT_REL;
            player_d = 1'b0;
            timer_d  = '0;
            timeout  = 1'b0;
        end
    end

    // Move FSM state, latched cell, current player and turn timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cell_q   <= '0;
            player_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            cell_q   <= cell_d;
            player_q <= player_d;
            timer_q  <= timer_d;
        end
    end

    assign move_valid  = (state_q == OFFER);
    assign move_cell   = cell_q;
    assign move_onehot = move_valid ? (9'd1 << cell_q) : 9'd0;
    assign move_player = player_q;

endmodule
